// File: rtl/det_pkg.sv
// Shared sizing for the detection event logger: default widths and the saturating counter helper.
package det_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W     = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/det_fifo.sv
// Synchronous first-word-fall-through FIFO; dout reads 0 when empty.
// A push while full is taken only when a pop happens in the same cycle.
module det_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/det_event_logger.sv
// Timestamps detector pulses into a FIFO with accepted-event count and sticky overflow.
// Optional DET_DROP_CNT_EN adds a saturating count of dropped events on drop_cnt.
module det_event_logger
  import det_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             clr,
  output logic [TS_W-1:0]  ts_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] count_out,
  output logic             overflow
`ifdef DET_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  logic [TS_W-1:0] ts_cnt;
  logic            det;
  logic            pop;
  logic            accept;
  logic            drop;
  logic            full;
  logic            empty;

  assign det       = in & en;
  assign valid_out = ~empty;
  assign pop       = valid_out & ready_in;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign accept    = det & (~full | pop);
  assign drop      = det & full & ~pop;

  det_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (det),
    .din   (ts_cnt),
    .pop   (pop),
    .dout  (ts_out),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt    <= '0;
      count_out <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      ts_cnt    <= '0;
      count_out <= '0;
      overflow  <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (accept) count_out <= sat_inc(count_out);
      if (drop)   overflow  <= 1'b1;
    end
  end

`ifdef DET_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       drop_cnt <= '0;
    else if (clr)  drop_cnt <= '0;
    else if (drop) drop_cnt <= sat_inc(drop_cnt);
  end
`endif

endmodule

// File: doc/det_event_logger.md
DET_EVENT_LOGGER -- requirements
Module: det_event_logger

Interface
REQ-001 SHALL have parameter TS_W, default 16, timestamp width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, event FIFO depth in entries, power of two and at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in  input  1  detection pulse from the upstream sequence detector's out; one event per high cycle.
REQ-006 SHALL have port en  input  1  logging enable; when low, detections are ignored.
REQ-007 SHALL have port clr  input  1  synchronous clear of FIFO, counters and flags.
REQ-008 SHALL have port ts_out  output  TS_W  timestamp at the FIFO head.
REQ-009 SHALL have port valid_out  output  1  high when the FIFO is not empty.
REQ-010 SHALL have port ready_in  input  1  consumer ready; a pop occurs when valid_out and ready_in are both high.
REQ-011 SHALL have port count_out  output  8  accepted-event count, saturating.
REQ-012 SHALL have port overflow  output  1  sticky flag, set when an event is dropped.

Function
REQ-013 SHALL run a free-running TS_W-bit timestamp counter that increments every cycle and wraps from all-ones to 0.
REQ-014 SHALL treat a detection as in=1 and en=1 at a rising edge, and SHALL push the counter value sampled at that same edge.
REQ-015 SHALL present the head entry as first-word fall-through: a push into an empty FIFO gives valid_out=1 and ts_out=value one cycle later.
REQ-016 SHALL, on a pop, remove the head and show the next entry on the following cycle (or drop valid_out if the FIFO is now empty).
REQ-017 SHALL, on simultaneous push and pop, perform both and leave occupancy unchanged, including when the FIFO is full.
REQ-018 SHALL, on a push while full without a pop, drop the event, set overflow, and leave FIFO contents and count_out unchanged.
REQ-019 SHALL increment count_out by 1 per accepted push and hold it at 255 once reached.
REQ-020 SHALL hold ts_out stable while valid_out=1 and ready_in=0.
REQ-021 SHALL, on clr=1, empty the FIFO and zero the timestamp counter, count_out and overflow at that edge; clr takes priority over a same-cycle push or pop.
REQ-022 SHALL drive ts_out to 0 while the FIFO is empty.

Reset
REQ-023 SHALL, while rst=1, immediately force valid_out=0, ts_out=0, count_out=0, overflow=0, the timestamp counter to 0 and FIFO pointers to 0.
REQ-024 SHALL discard any in-flight FIFO content when reset asserts mid-operation, and SHALL accept a detection on the first rising edge after rst deasserts with timestamp 0.

Configuration
REQ-025 SHALL, when DET_DROP_CNT_EN is defined, add output drop_cnt (8 bits, reset 0, cleared by clr) that counts dropped events and saturates at 255.
REQ-026 SHALL, when DET_DROP_CNT_EN is undefined, omit the drop_cnt port and its logic, with all other behaviour unchanged.

Structure
REQ-027 SHALL take the TS_W and DEPTH defaults and the count width (8) from shared package det_pkg.
REQ-028 SHALL implement the storage as sub-module det_fifo (synchronous FIFO with full/empty flags and simultaneous push/pop), instantiated once.

Verification
REQ-029 SHALL cover release of rst, then in=1 for one cycle at timestamp 5 with ready_in=0 -> valid_out=1, ts_out=5, count_out=1.
REQ-030 SHALL cover 10 pulses with en=1 and ready_in=0, DEPTH=8 -> 8 entries stored, overflow=1, count_out=8, and drop_cnt=2 if DET_DROP_CNT_EN is defined.
REQ-031 SHALL cover a full FIFO with in=1 and ready_in=1 in the same cycle -> occupancy stays 8, new timestamp is appended, overflow stays 0.
REQ-032 SHALL cover en=0 with in toggling for 20 cycles -> valid_out=0, count_out=0.
REQ-033 SHALL cover TS_W=4 with a pulse at counter value 15 and another 2 cycles later -> popped timestamps are 15 then 1.
REQ-034 SHALL cover clr asserted together with in=1 while 3 entries are stored -> next cycle valid_out=0, count_out=0, overflow=0.
